modadd_arbiter: RTL and testbench
=================================

Name: modadd_arbiter

Overview:
- Shares one modadd instance, configured with IS_Q_FIXED=0, among NREQ requesters, for example the butterfly-unit and twiddle-update paths in the NTT core.
- Round-robin arbitration with a valid/ready request side.
- Registered operand issue to the adder.
- Tag pipeline that routes each sum back to its requester with the adder's latency.
- Runtime modulus q register, updated safely once the adder pipeline has drained.

Parameters:
- LOGQ, 32, operand/modulus width in bits.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester-ID width; must equal clog2(NREQ).
- ADD_LAT, 2, modadd latency from a/b to c; 1 when modadd DELAY_ADD==1, otherwise 2.
- Q_RST, 0, reset value of the modulus register.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  NREQ*LOGQ  packed operand a; requester i occupies [i*LOGQ +: LOGQ]
- req_b  in  NREQ*LOGQ  packed operand b, same packing
- add_a  out  LOGQ  to modadd a
- add_b  out  LOGQ  to modadd b
- add_q  out  LOGQ  to modadd q
- add_c  in  LOGQ  from modadd c
- rsp_valid  out  1  result valid (no backpressure)
- rsp_id  out  IDW  requester that owns rsp_c
- rsp_c  out  LOGQ  (a+b) mod q, passthrough of add_c
- cfg_q_we  in  1  request to load a new modulus
- cfg_q  in  LOGQ  new modulus value
- cfg_busy  out  1  modulus update pending

Behaviour:
- Reset (async assert, sync deassert handled outside): values forced while rst_n=0:
  - add_a=0, add_b=0, add_q=Q_RST
  - rr_ptr=NREQ-1, tag pipeline valids=0
  - pending=0, so rsp_valid=0 and cfg_busy=0
  - Reset mid-operation discards all in-flight work; no response is ever produced for it.
- Arbitration (combinational grant):
  - Eligible when req_valid[i]=1 and pending=0.
  - Search starts at (rr_ptr+1) mod NREQ and wraps; the first eligible index wins.
  - req_ready=onehot(winner), or 0 when nothing is eligible.
  - An accept occurs when req_valid[i]&req_ready[i]. On accept, rr_ptr<=winner.
  - Requesters hold valid and operands stable until accepted; this is checked by assertion, not by the RTL.
- Issue: on an accept in cycle t:
  - add_a/add_b <= the winner's operands; add_a/add_b are registered and otherwise hold their value.
  - The tag pipeline stage 0 gets {1, winner}. With no accept, stage 0 gets valid=0.
- Tag pipeline: ADD_LAT stages of {valid, id}, shifting every cycle.
  - rsp_valid and rsp_id come from the last stage; rsp_c=add_c.
  - Accept at cycle t gives rsp_valid at cycle t+1+ADD_LAT.
  - Throughput is one accept per cycle, sustained.
- In-flight count = number of valid stages; width clog2(ADD_LAT+1)+1. It is derived from the tag valids, not from a separate counter.
- Modulus update:
  - cfg_q_we=1 captures cfg_q into q_pend and sets pending.
  - A second write while pending overwrites q_pend.
  - While pending, req_ready=0.
  - In the first cycle the tag pipeline is all-invalid, add_q<=q_pend and pending clears; grants resume the next cycle.
  - A write in the same cycle an accept would occur blocks that accept, because pending takes effect combinationally from cfg_q_we as well.
  - cfg_busy=pending|cfg_q_we.
- add_q is constant while any operation is in flight.
- Arithmetic correctness relies on a,b<q. The arbiter does not reduce operands.
- NREQ=1 degenerates to a pass-through with the latency register and tag pipeline.

Decomposition:
- Shared package ntt_pkg holds:
  - LOGQ default
  - the ADD_LAT derivation function from DELAY_ADD
  - a clog2 function
- One sub-module, rr_arbiter (NREQ; inputs req, ptr; output onehot grant plus index), is reused by other shared-resource controllers.
- modadd itself is instantiated by the parent, not inside this block.

Test Plan:
- Reset/idle, with q loaded as 12289 via cfg, then req0: a=12000, b=500.
  - Expect rsp_valid exactly 1+ADD_LAT cycles after accept, rsp_id=0, rsp_c=211.
- All four requesters valid continuously, each with distinct (a,b).
  - Grants cycle 0,1,2,3,0,… with one grant per cycle.
  - Responses arrive in grant order with correct ids, e.g. req2 a=5, b=7 gives 12.
- Sparse fairness: req1 and req3 are always valid.
  - Grants alternate 1,3,1,3, and rr_ptr wraps correctly past index 3.
- Modulus change while busy: stream requests, then pulse cfg_q_we with cfg_q=7681.
  - req_ready drops the same cycle, and in-flight results still use 12289.
  - add_q changes only after the pipeline is empty.
  - A next op a=7000, b=1000 gives 319.
- Reset mid-stream: assert rst_n=0 with 2 ops in flight.
  - rsp_valid=0 immediately and stays 0 after release.
  - add_q=Q_RST and grants restart from requester 0.
- Boundary sums:
  - a=q-1, b=1 gives 0.
  - a=0, b=0 gives 0.
  - a=q-1, b=q-1 gives q-2.
  - Cover both ADD_LAT=1 and ADD_LAT=2 builds.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and elaboration-time helpers for the NTT datapath blocks.
package ntt_pkg;

  localparam int LOGQ_DEFAULT = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // modadd keeps its output register unless DELAY_ADD==1 folds it into the add stage.
  function automatic int add_lat_of(input int delay_add);
    return (delay_add == 1) ? 1 : 2;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after ptr+1, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_valid
);

  logic [IDW-1:0] idx;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    idx         = '0;
    // Walk from the farthest candidate back to ptr+1; the nearest eligible one is written last.
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        grant       = '0;
        grant[idx]  = 1'b1;
        grant_id    = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/modadd_arbiter.sv
// Time-shares one external modadd among NREQ requesters and routes each sum back to
// its owner; the modulus register is swapped only once the adder pipeline is empty.
module modadd_arbiter
  import ntt_pkg::*;
#(
  parameter int               LOGQ    = LOGQ_DEFAULT,
  parameter int               NREQ    = 4,
  parameter int               IDW     = 2,
  parameter int               ADD_LAT = 2,
  parameter logic [LOGQ-1:0]  Q_RST   = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*LOGQ-1:0] req_a,
  input  logic [NREQ*LOGQ-1:0] req_b,
  output logic [LOGQ-1:0]      add_a,
  output logic [LOGQ-1:0]      add_b,
  output logic [LOGQ-1:0]      add_q,
  input  logic [LOGQ-1:0]      add_c,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [LOGQ-1:0]      rsp_c,
  input  logic                 cfg_q_we,
  input  logic [LOGQ-1:0]      cfg_q,
  output logic                 cfg_busy
);

  // One stage for the operand issue register plus one per adder stage.
  localparam int DEPTH = ADD_LAT + 1;
  localparam int CNTW  = clog2(ADD_LAT + 1) + 1;

  logic [IDW-1:0]  rr_ptr;
  logic            pending;
  logic [LOGQ-1:0] q_pend;
  logic [DEPTH-1:0] tag_v;
  logic [IDW-1:0]  tag_id [DEPTH];
  logic [CNTW-1:0] inflight;
  logic [NREQ-1:0] eligible;
  logic [IDW-1:0]  win_id;
  logic            accept;
  logic [LOGQ-1:0] win_a;
  logic [LOGQ-1:0] win_b;

  // A modulus write blocks grants in the same cycle, before pending is even set.
  assign eligible = (pending | cfg_q_we) ? '0 : req_valid;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req         (eligible),
    .ptr         (rr_ptr),
    .grant       (req_ready),
    .grant_id    (win_id),
    .grant_valid (accept)
  );

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        win_a = req_a[i*LOGQ +: LOGQ];
        win_b = req_b[i*LOGQ +: LOGQ];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int s = 0; s < DEPTH; s++) inflight = inflight + CNTW'(tag_v[s]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= IDW'(NREQ - 1);
      add_a   <= '0;
      add_b   <= '0;
      add_q   <= Q_RST;
      q_pend  <= Q_RST;
      pending <= 1'b0;
      tag_v   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      tag_v <= {tag_v[DEPTH-2:0], accept};
      if (accept) begin
        rr_ptr <= win_id;
        add_a  <= win_a;
        add_b  <= win_b;
      end
      if (cfg_q_we) begin
        q_pend  <= cfg_q;
        pending <= 1'b1;
      end else if (pending && inflight == '0) begin
        add_q   <= q_pend;
        pending <= 1'b0;
      end
    end
  end

  // NOTE: the id array is not reset; tag_v qualifies every entry, so stale ids are never observed.
  always_ff @(posedge clk) begin
    tag_id[0] <= win_id;
    for (int s = 1; s < DEPTH; s++) tag_id[s] <= tag_id[s-1];
  end

  assign rsp_valid = tag_v[DEPTH-1];
  assign rsp_id    = tag_id[DEPTH-1];
  assign rsp_c     = add_c;
  assign cfg_busy  = pending | cfg_q_we;

endmodule

// File: tb/tb_modadd_arbiter.sv
// Drives two arbiter builds (ADD_LAT=2 and ADD_LAT=1) with the same stimulus, each
// behind its own modadd model and response scoreboard.
`timescale 1ns/1ps
module tb_modadd_arbiter;

  localparam int LOGQ = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct {
    logic [IDW-1:0]  id;
    logic [LOGQ-1:0] c;
    int              cyc;
  } exp_t;

  logic                 clk       = 1'b0;
  logic                 rst_n     = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*LOGQ-1:0] req_a     = '0;
  logic [NREQ*LOGQ-1:0] req_b     = '0;
  logic                 cfg_q_we  = 1'b0;
  logic [LOGQ-1:0]      cfg_q     = '0;
  logic                 one_shot  = 1'b0;
  logic [LOGQ-1:0]      exp_q     = '0;
  int cyc       = 0;
  int n_asserts = 0;
  int n_fail    = 0;

  logic [1:0][NREQ-1:0] ready_v;
  logic [1:0]           rsp_valid_v;
  logic [1:0]           busy_v;
  logic [1:0][IDW-1:0]  rsp_id_v;
  logic [1:0][LOGQ-1:0] rsp_c_v;
  logic [1:0][LOGQ-1:0] add_a_v;
  logic [1:0][LOGQ-1:0] add_q_v;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [LOGQ-1:0] modsum(input logic [LOGQ-1:0] a, input logic [LOGQ-1:0] b,
                                             input logic [LOGQ-1:0] q);
    logic [LOGQ:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (q == '0) return s[LOGQ-1:0];
    return LOGQ'(s % {1'b0, q});
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int LAT = (k == 0) ? 2 : 1;
    logic [LOGQ-1:0] add_b;
    logic [LOGQ-1:0] add_c;
    logic [LOGQ-1:0] c_pipe [LAT];
    logic [NREQ-1:0] served = '0;
    logic [NREQ-1:0] vld;
    exp_t sb[$];
    int   sb_len = 0;

    // In one-shot mode each requester is withdrawn once this build has accepted it.
    assign vld = req_valid & ~served;
    always @(posedge clk) served <= one_shot ? (served | (vld & ready_v[k])) : '0;

    modadd_arbiter #(
      .LOGQ    (LOGQ),
      .NREQ    (NREQ),
      .IDW     (IDW),
      .ADD_LAT (LAT),
      .Q_RST   ('0)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (vld),
      .req_ready (ready_v[k]),
      .req_a     (req_a),
      .req_b     (req_b),
      .add_a     (add_a_v[k]),
      .add_b     (add_b),
      .add_q     (add_q_v[k]),
      .add_c     (add_c),
      .rsp_valid (rsp_valid_v[k]),
      .rsp_id    (rsp_id_v[k]),
      .rsp_c     (rsp_c_v[k]),
      .cfg_q_we  (cfg_q_we),
      .cfg_q     (cfg_q),
      .cfg_busy  (busy_v[k])
    );

    // Reference modadd: LAT register stages from a/b/q to c.
    always @(posedge clk) begin
      c_pipe[0] <= modsum(add_a_v[k], add_b, add_q_v[k]);
      for (int s = 1; s < LAT; s++) c_pipe[s] <= c_pipe[s-1];
    end
    assign add_c = c_pipe[LAT-1];

    always @(negedge clk) begin
      exp_t e;
      logic [NREQ-1:0] acc;
      if (!rst_n) begin
        sb.delete();
      end else begin
        if (rsp_valid_v[k]) begin
          n_asserts++;
          assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL rsp_unexpected[lat%0d]: observed id=%0d c=%0d, expected no response", LAT,
                   rsp_id_v[k], rsp_c_v[k]);
          end
          if (sb.size() > 0) begin
            e = sb.pop_front();
            n_asserts++;
            assert ({rsp_id_v[k], rsp_c_v[k]} === {e.id, e.c}) else begin
              n_fail++;
              $error("FAIL rsp_data[lat%0d]: observed id=%0d c=%0d, expected id=%0d c=%0d", LAT,
                     rsp_id_v[k], rsp_c_v[k], e.id, e.c);
            end
            n_asserts++;
            assert (cyc === e.cyc) else begin
              n_fail++;
              $error("FAIL rsp_cycle[lat%0d]: observed %0d, expected %0d", LAT, cyc, e.cyc);
            end
          end
        end
        n_asserts++;
        assert ($onehot0(ready_v[k])) else begin
          n_fail++;
          $error("FAIL ready_onehot[lat%0d]: observed %b, expected one-hot or zero", LAT, ready_v[k]);
        end
        acc = vld & ready_v[k];
        for (int i = 0; i < NREQ; i++) begin
          if (acc[i]) begin
            e.id  = IDW'(i);
            e.c   = modsum(req_a[i*LOGQ +: LOGQ], req_b[i*LOGQ +: LOGQ], exp_q);
            e.cyc = cyc + 1 + LAT;
            sb.push_back(e);
          end
        end
      end
      sb_len = sb.size();
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [LOGQ-1:0] a, input logic [LOGQ-1:0] b);
    req_a[i*LOGQ +: LOGQ] = a;
    req_b[i*LOGQ +: LOGQ] = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat [2];
    logic [LOGQ-1:0] rc [2];
    logic [IDW-1:0]  rid [2];
    logic [LOGQ-1:0] ta [3];
    logic [LOGQ-1:0] tb [3];

    // Reset state.
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_rsp_valid%0d", k), 64'(rsp_valid_v[k]), 0);
      check($sformatf("rst_busy%0d", k), 64'(busy_v[k]), 0);
      check($sformatf("rst_add_q%0d", k), 64'(add_q_v[k]), 0);
      check($sformatf("rst_add_a%0d", k), 64'(add_a_v[k]), 0);
    end
    tick();
    rst_n = 1'b1;
    tick();

    // Load q = 12289 through the config port.
    cfg_q_we = 1'b1;
    cfg_q    = 32'd12289;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check($sformatf("cfg_busy_we%0d", k), 64'(busy_v[k]), 1);
    tick();
    cfg_q_we = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check($sformatf("cfg_busy_pend%0d", k), 64'(busy_v[k]), 1);
    tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("cfg_busy_done%0d", k), 64'(busy_v[k]), 0);
      check($sformatf("cfg_add_q%0d", k), 64'(add_q_v[k]), 12289);
    end
    exp_q = 32'd12289;
    tick();

    // Single op from requester 0: 12000 + 500 mod 12289 = 211.
    set_op(0, 32'd12000, 32'd500);
    req_valid = 4'b0001;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check($sformatf("first_grant%0d", k), 64'(ready_v[k]), 4'b0001);
    tick();
    req_valid = '0;
    lat = '{-1, -1};
    rc  = '{'0, '0};
    rid = '{'0, '0};
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rsp_valid_v[k] && lat[k] < 0) begin
          lat[k] = n;
          rc[k]  = rsp_c_v[k];
          rid[k] = rsp_id_v[k];
        end
      end
    end
    check("first_latency_lat2", 64'(lat[0]), 3);
    check("first_latency_lat1", 64'(lat[1]), 2);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("first_c%0d", k), 64'(rc[k]), 211);
      check($sformatf("first_id%0d", k), 64'(rid[k]), 0);
    end
    tick();

    // All four valid: one grant per cycle, rotating from the requester after the last winner.
    set_op(0, 32'd100, 32'd200);
    set_op(1, 32'd300, 32'd400);
    set_op(2, 32'd5, 32'd7);
    set_op(3, 32'd1000, 32'd2000);
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        check($sformatf("rr_all%0d_step%0d", k, i), 64'(ready_v[k]), 64'(1) << ((1 + i) % NREQ));
      tick();
    end

    // Sparse: only 1 and 3 valid, grants alternate and the pointer wraps past 3.
    req_valid = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        check($sformatf("rr_sparse%0d_step%0d", k, i), 64'(ready_v[k]), (i % 2 == 0) ? 4'b0010 : 4'b1000);
      tick();
    end
    req_valid = '0;
    repeat (6) tick();

    // Modulus change while ops are in flight; includes the q-2 boundary at q=12289.
    ta = '{32'd11000, 32'd12288, 32'd6000};
    tb = '{32'd1289, 32'd12288, 32'd6000};
    req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      set_op(0, ta[i], tb[i]);
      @(negedge clk);
      for (int k = 0; k < 2; k++) check($sformatf("stream%0d_step%0d", k, i), 64'(ready_v[k]), 4'b0001);
      tick();
    end
    one_shot  = 1'b1;
    req_valid = 4'b0100;
    set_op(2, 32'd7000, 32'd1000);
    cfg_q_we  = 1'b1;
    cfg_q     = 32'd7681;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("cfg_blocks_ready%0d", k), 64'(ready_v[k]), 0);
      check($sformatf("cfg_busy_same_cycle%0d", k), 64'(busy_v[k]), 1);
    end
    tick();
    cfg_q_we = 1'b0;
    exp_q    = 32'd7681;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (busy_v[k]) begin
          check($sformatf("drain_add_q%0d_step%0d", k, i), 64'(add_q_v[k]), 12289);
          check($sformatf("drain_ready%0d_step%0d", k, i), 64'(ready_v[k]), 0);
        end else begin
          check($sformatf("new_add_q%0d_step%0d", k, i), 64'(add_q_v[k]), 7681);
        end
      end
      tick();
    end
    check("resume_served_lat2", 64'(g_dut[0].served[2]), 1);
    check("resume_served_lat1", 64'(g_dut[1].served[2]), 1);
    req_valid = '0;
    one_shot  = 1'b0;
    tick();

    // Boundary sums at q=7681: q-1+1, 0+0, (q-1)+(q-1).
    set_op(1, 32'd7680, 32'd1);
    set_op(3, 32'd0, 32'd0);
    set_op(0, 32'd7680, 32'd7680);
    one_shot  = 1'b1;
    req_valid = 4'b1011;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check($sformatf("bound_grant%0d", k), 64'(ready_v[k]), 4'b1000);
    repeat (4) tick();
    req_valid = '0;
    one_shot  = 1'b0;
    repeat (6) tick();

    // Reset with ops in flight.
    set_op(0, 32'd10, 32'd20);
    set_op(1, 32'd30, 32'd40);
    req_valid = 4'b0011;
    repeat (2) tick();
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("midrst_rsp_valid%0d", k), 64'(rsp_valid_v[k]), 0);
      check($sformatf("midrst_add_q%0d", k), 64'(add_q_v[k]), 0);
      check($sformatf("midrst_busy%0d", k), 64'(busy_v[k]), 0);
    end
    exp_q = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) check($sformatf("postrst_quiet%0d_step%0d", k, i), 64'(rsp_valid_v[k]), 0);
      tick();
    end
    set_op(0, 32'd0, 32'd0);
    one_shot  = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check($sformatf("postrst_grant%0d", k), 64'(ready_v[k]), 4'b0001);
    repeat (4) tick();
    req_valid = '0;
    one_shot  = 1'b0;
    repeat (8) tick();

    check("sb_drained_lat2", 64'(g_dut[0].sb_len), 0);
    check("sb_drained_lat1", 64'(g_dut[1].sb_len), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
